// File: rtl/circuitgen_eq_pkg.sv
// Shared types and defaults for the exhaustive equivalence sweeper.
// Holds the sweep FSM state encoding and the default MISR constants.
package circuitgen_eq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int          SIG_W_DEF    = 16;
  localparam logic [15:0] SIG_POLY_DEF = 16'h1021;
  localparam logic [15:0] SIG_SEED_DEF = 16'hFFFF;

endpackage

// File: rtl/eq_misr.sv
// Multiple-input signature register compressing one CUT output stream.
// clr reloads the seed; en folds d into the signature.
module eq_misr
  import circuitgen_eq_pkg::*;
#(
  parameter int               SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0] SIG_SEED = {SIG_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIG_W-1:0] d,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic [SIG_W-1:0] fb;

  assign fb = sig_q[SIG_W-1] ? SIG_POLY : '0;

  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = SIG_SEED;
    end else if (en) begin
      sig_d = {sig_q[SIG_W-2:0], 1'b0} ^ fb ^ d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= SIG_SEED;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/circuit_equiv_sweeper.sv
// Drives every input vector into two CUT copies, counts masked output
// mismatches, records the first failing vector and signs both streams.
module circuit_equiv_sweeper
  import circuitgen_eq_pkg::*;
#(
  parameter int               N_IN     = 4,
  parameter int               N_OUT    = 9,
  parameter int               DUT_LAT  = 0,
  parameter int               SIG_W    = SIG_W_DEF,
  parameter logic [SIG_W-1:0] SIG_POLY = SIG_W'(SIG_POLY_DEF),
  parameter logic [SIG_W-1:0] SIG_SEED = {SIG_W{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [N_OUT-1:0] cmp_mask,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f_a,
  input  logic [N_OUT-1:0] f_b,
  output logic             busy,
  output logic             done,
  output logic             equal,
  output logic [N_IN:0]    mismatch_cnt,
  output logic             first_fail_v,
  output logic [N_IN-1:0]  first_fail_x,
  output logic [SIG_W-1:0] sig_a,
  output logic [SIG_W-1:0] sig_b
);

  localparam int WC_W = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(DUT_LAT);
  localparam logic [N_IN-1:0] X_MAX  = '1;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [N_IN:0]    cnt_q, cnt_d;
  logic             ffv_q, ffv_d;
  logic [N_IN-1:0]  ffx_q, ffx_d;
  logic [N_OUT-1:0] mask_q, mask_d;

  logic go;
  logic run_ok;
  logic last_w;
  logic sample;
  logic miss;

  assign go     = start & ~abort & (state_q != S_RUN);
  assign run_ok = (state_q == S_RUN) & ~abort;
  assign last_w = (wcnt_q == WC_MAX);
  assign sample = run_ok & last_w;
  assign miss   = |((f_a ^ f_b) & mask_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (go) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (sample && (x_q == X_MAX)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (go) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    equal = (state_q == S_DONE) && (cnt_q == '0);
  end

  // f_a/f_b only reach state under sample, so X elsewhere is harmless
  always_comb begin
    x_d    = x_q;
    wcnt_d = wcnt_q;
    cnt_d  = cnt_q;
    ffv_d  = ffv_q;
    ffx_d  = ffx_q;
    mask_d = mask_q;
    if (go) begin
      x_d    = '0;
      wcnt_d = '0;
      cnt_d  = '0;
      ffv_d  = 1'b0;
      ffx_d  = '0;
      mask_d = cmp_mask;
    end else if (run_ok) begin
      if (last_w) begin
        wcnt_d = '0;
        if (miss) begin
          cnt_d = cnt_q + 1'b1;
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffx_d = x_q;
          end
        end
        if (x_q != X_MAX) x_d = x_q + 1'b1;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q    <= '0;
      wcnt_q <= '0;
      cnt_q  <= '0;
      ffv_q  <= 1'b0;
      ffx_q  <= '0;
      mask_q <= '0;
    end else begin
      x_q    <= x_d;
      wcnt_q <= wcnt_d;
      cnt_q  <= cnt_d;
      ffv_q  <= ffv_d;
      ffx_q  <= ffx_d;
      mask_q <= mask_d;
    end
  end

  assign x            = x_q;
  assign mismatch_cnt = cnt_q;
  assign first_fail_v = ffv_q;
  assign first_fail_x = ffx_q;

  eq_misr #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr_a (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .en (sample),
    .d  (SIG_W'(f_a)),
    .sig(sig_a)
  );

  eq_misr #(
    .SIG_W   (SIG_W),
    .SIG_POLY(SIG_POLY),
    .SIG_SEED(SIG_SEED)
  ) u_misr_b (
    .clk(clk),
    .rst(rst),
    .clr(go),
    .en (sample),
    .d  (SIG_W'(f_b)),
    .sig(sig_b)
  );

endmodule
